// File: rtl/ei_mem_arbiter.sv
// Two-requester round-robin arbiter serialising register reads/writes onto the
// single-port EI register memory, with range checking and EIR_ERROR write protection.
module ei_mem_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 47,
  parameter int RO_IDX   = 46
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] RO_A = ADDR_W'(RO_IDX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   last, sel, sel_nxt, take;
  logic   t_we, t_err;

  logic              s_we, s_ok;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  logic [1:0]             gnt_q, done_q, err_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Requests are only looked at in IDLE; a tie goes to whoever was not granted last.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          sel_nxt   = (req0 && req1) ? ~last : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_we    = sel_nxt ? we1    : we0;
    s_addr  = sel_nxt ? addr1  : addr0;
    s_wdata = sel_nxt ? wdata1 : wdata0;
    s_ok    = ({1'b0, s_addr} < LIM) && !(s_we && (s_addr == RO_A));
  end

  // Memory strobe is registered together with the grant so both land in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      sel       <= 1'b0;
      t_we      <= 1'b0;
      t_err     <= 1'b0;
      gnt_q     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt_q  <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (take) begin
        last           <= sel_nxt;
        sel            <= sel_nxt;
        t_we           <= s_we;
        t_err          <= ~s_ok;
        gnt_q[sel_nxt] <= 1'b1;
        mem_en         <= s_ok;
        mem_we         <= s_we && s_ok;
        mem_addr       <= s_addr;
        mem_wdata      <= s_wdata;
      end
    end
  end

  // Response registers per requester; rdata/err hold until that side's next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      if (state == RESP) begin
        done_q[sel]  <= 1'b1;
        err_q[sel]   <= t_err;
        rdata_q[sel] <= (t_we || t_err) ? '0 : mem_rdata;
      end
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
endmodule

// File: doc/ei_mem_arbiter.md
Name: ei_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port EI register memory holding the ei_regs_t register set (EIR_TEST .. EIR_ERROR, indices 0..46).
- Requester 0 is the host command decoder; requester 1 is the BLE setup sequencer.
- Serialises their read/write transactions onto one memory port with round-robin fairness, range checking and write protection of EIR_ERROR.
- Returns a completion pulse with read data or an error to the granted requester.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 6, register index width (matches ei_regs_t)
- NUM_REGS, 47, count of valid register indices (0..NUM_REGS-1)
- RO_IDX, 46, index of the read-only register (EIR_ERROR)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0, req1  in  1  transaction request, held until grant
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_W  register index
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle grant pulse
- done0, done1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  DATA_W  read data, valid with done
- err0, err1  out  1  error flag, valid with done
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory index
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en

Behaviour:
- Reset and outputs:
  - Reset is asynchronous and active-high.
  - All outputs are registered and reset to 0; FSM resets to IDLE; last-grant pointer resets to 1, so req0 wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE (T0):
  - req0/req1 are sampled only in this state.
  - If neither is set, stay in IDLE.
  - If exactly one is set, select it.
  - If both are set, select the requester not equal to the last-grant pointer.
  - On selection, latch that requester's we/addr/wdata, update the pointer and go to ACCESS.
- ACCESS (T1):
  - gnt of the selected requester = 1 for this cycle only.
  - If the request is valid, mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values.
  - Invalid request: addr >= NUM_REGS, or we = 1 with addr == RO_IDX. For an invalid request, mem_en = 0 and an error flag is latched.
  - Go to RESP.
- RESP (T2):
  - mem_en = 0.
  - Capture mem_rdata for a valid read; capture 0 for writes and for errors.
  - Go to IDLE.
- Completion (T3, in IDLE):
  - done of the selected requester = 1 for one cycle.
  - rdata holds the captured value; err is set if the request was invalid.
  - rdata/err hold their values until that requester's next done.
  - A new request can be sampled in the same cycle, so its gnt arrives at T4.
- Latency and throughput:
  - Request to gnt is 1 cycle; request to done is 3 cycles.
  - At most one transaction per 3 cycles.
  - Only one gnt/done is asserted at a time.
- Requester rules:
  - A requester must hold req/we/addr/wdata stable until gnt and drop req in the cycle after gnt.
  - A req still high in a later IDLE cycle is treated as a new transaction.
- Round-robin: under continuous requests from both sides, grants strictly alternate (0, 1, 0, 1, ...).
- Reset mid-transaction: any in-flight access is abandoned with no gnt/done/mem_en after reset; memory contents are not this block's concern.

Test Plan:
- Single read: mem holds 0x5A at index 6 (EIR_ADV_INT); req0 read addr 6 at T0 -> gnt0 at T1; mem_en = 1, mem_we = 0, mem_addr = 6 at T1; done0 = 1, rdata0 = 0x5A, err0 = 0 at T3.
- Single write: req1 write addr 30 (EIR_BAUD_RATE), wdata 0x04 -> gnt1 at T1 with mem_en = 1, mem_we = 1, mem_addr = 30, mem_wdata = 0x04; done1 at T3 with rdata1 = 0, err1 = 0.
- Contention: req0 and req1 both held asserted from reset -> gnt0 at T1, gnt1 at T4, gnt0 at T7; done0 at T3, done1 at T6; never both gnt in one cycle.
- Out of range: req0 read addr 50 -> gnt0 at T1, mem_en stays 0 throughout, done0 = 1 and err0 = 1 with rdata0 = 0 at T3.
- Read-only: req1 write addr 46 -> no mem_en, done1 with err1 = 1 at T3; a subsequent req1 read addr 46 -> mem_en = 1, err1 = 0.
- Reset mid-op: assert rst during ACCESS of a req0 read -> all outputs 0 immediately (asynchronous), no done0; after release, req1 alone is granted and the pointer favours req0 on the next tie.
